// File: rtl/delayed_resp_tracker_if.sv
// Handshake bundle between the MMIO write path, the fabric port and the delayed-register sync stage.
// slave = tracker side, master = the environment that drives pushes and fabric responses.
interface delayed_resp_tracker_if #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
);
  localparam int PC_W = $clog2(DEPTH) + 1;

  logic              req_push;
  logic [DATA_W-1:0] req_data;
  logic              req_full;
  logic              fab_req_valid;
  logic              fab_req_ready;
  logic [DATA_W-1:0] fab_req_data;
  logic              fab_resp_valid;
  logic              delayed_valid;
  logic [DATA_W-1:0] delayed_data;
  logic              timeout_err;
  logic              ovf_err;
  logic [PC_W-1:0]   pending_cnt;

  modport slave (
    input  req_push, req_data, fab_req_ready, fab_resp_valid,
    output req_full, fab_req_valid, fab_req_data, delayed_valid, delayed_data,
           timeout_err, ovf_err, pending_cnt
  );

  modport master (
    output req_push, req_data, fab_req_ready, fab_resp_valid,
    input  req_full, fab_req_valid, fab_req_data, delayed_valid, delayed_data,
           timeout_err, ovf_err, pending_cnt
  );
endinterface

// File: rtl/delayed_resp_tracker.sv
// Queues delayed MMIO writes, issues them one at a time, pulses delayed_valid 1 cycle after response/timeout.
// Push->fab_req_valid >= 2 cycles; pushes while full are dropped (ovf_err). Perf counters: DELAYED_TRACKER_PERF_EN.
module delayed_resp_tracker #(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input  logic                  clk,
  input  logic                  resetn,
  delayed_resp_tracker_if.slave bus
`ifdef DELAYED_TRACKER_PERF_EN
  ,
  output logic [31:0]           perf_done_cnt,
  output logic [CNT_W-1:0]      perf_max_lat
`endif
);
  localparam int AW   = $clog2(DEPTH);
  localparam int PC_W = AW + 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0]  r_cnt;
  logic              r_timeout_err;
  logic              r_ovf_err;

  logic [PC_W-1:0]   w_pending;
  logic              w_full;
  logic              w_push_ok;
  logic [DATA_W-1:0] w_head;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_to_hit;
  logic              w_fab_vld;
  logic              w_dly_vld;
  logic              w_accept;
  logic              w_to_retire;

  // Extra pointer bit distinguishes full from empty; difference is the occupancy.
  assign w_pending = r_wr_ptr - r_rd_ptr;
  assign w_full    = (w_pending == PC_W'(DEPTH));
  assign w_push_ok = bus.req_push && !w_full;
  assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_to_hit  = (w_cnt_inc == TO_VAL);

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= bus.req_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fab_vld   = 1'b0;
    w_dly_vld   = 1'b0;
    w_accept    = 1'b0;
    w_to_retire = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pending != '0) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_fab_vld = 1'b1;
        if (bus.fab_req_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A response on the terminal-count cycle retires the entry cleanly.
        if (bus.fab_resp_valid) begin
          w_state_nxt = ST_DONE;
        end else if (w_to_hit) begin
          w_to_retire = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_dly_vld   = 1'b1;
        w_state_nxt = (w_pending > PC_W'(1)) ? ST_ISSUE : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
      r_ovf_err     <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_dly_vld) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_accept) begin
        r_cnt <= '0;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= w_cnt_inc;
      end
      if (w_to_retire) r_timeout_err <= 1'b1;
      if (bus.req_push && w_full) r_ovf_err <= 1'b1;
    end
  end

  assign bus.req_full      = w_full;
  assign bus.pending_cnt   = w_pending;
  assign bus.fab_req_valid = w_fab_vld;
  assign bus.fab_req_data  = w_fab_vld ? w_head : '0;
  assign bus.delayed_valid = w_dly_vld;
  assign bus.delayed_data  = w_dly_vld ? w_head : '0;
  assign bus.timeout_err   = r_timeout_err;
  assign bus.ovf_err       = r_ovf_err;

`ifdef DELAYED_TRACKER_PERF_EN
  logic [31:0]      r_perf_done;
  logic [CNT_W-1:0] r_perf_max;

  // Latency recorded is the cycle count from accept to response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_perf_done <= '0;
      r_perf_max  <= '0;
    end else begin
      if (w_dly_vld && (r_perf_done != 32'hFFFF_FFFF)) r_perf_done <= r_perf_done + 1'b1;
      if ((r_state == ST_WAIT) && bus.fab_resp_valid && (w_cnt_inc > r_perf_max)) begin
        r_perf_max <= w_cnt_inc;
      end
    end
  end

  assign perf_done_cnt = r_perf_done;
  assign perf_max_lat  = r_perf_max;
`endif
endmodule

// File: tb/tb_delayed_resp_tracker.sv
// Directed self-checking bench for delayed_resp_tracker (DEPTH=4, TIMEOUT=1023).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_delayed_resp_tracker;
  localparam int DW = 64;

  logic clk;
  logic resetn;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  delayed_resp_tracker_if #(.DATA_W(DW), .DEPTH(4)) bus ();

`ifdef DELAYED_TRACKER_PERF_EN
  logic [31:0] perf_done_cnt;
  logic [9:0]  perf_max_lat;
`endif

  delayed_resp_tracker #(.DATA_W(DW), .DEPTH(4), .TIMEOUT(1023), .CNT_W(10)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .bus           (bus)
`ifdef DELAYED_TRACKER_PERF_EN
    ,
    .perf_done_cnt (perf_done_cnt),
    .perf_max_lat  (perf_max_lat)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    resetn             = 1'b0;
    bus.req_push       = 1'b0;
    bus.req_data       = '0;
    bus.fab_req_ready  = 1'b0;
    bus.fab_resp_valid = 1'b0;
    step();
    step();
    resetn = 1'b1;
    step();
  endtask

  task automatic test_reset();
    resetn             = 1'b0;
    bus.req_push       = 1'b0;
    bus.req_data       = '0;
    bus.fab_req_ready  = 1'b0;
    bus.fab_resp_valid = 1'b0;
    step();
    total_cnt++;
    if ({bus.fab_req_valid, bus.delayed_valid, bus.req_full, bus.timeout_err, bus.ovf_err} !== 5'b0)
      $display("FAIL reset_flags got=%b exp=00000",
               {bus.fab_req_valid, bus.delayed_valid, bus.req_full, bus.timeout_err, bus.ovf_err});
    else pass_cnt++;
    total_cnt++;
    if (bus.pending_cnt !== 3'd0) $display("FAIL reset_pending got=%0d exp=0", bus.pending_cnt);
    else pass_cnt++;
    total_cnt++;
    if ({bus.fab_req_data, bus.delayed_data} !== 128'd0)
      $display("FAIL reset_data got=%0h/%0h exp=0/0", bus.fab_req_data, bus.delayed_data);
    else pass_cnt++;
`ifdef DELAYED_TRACKER_PERF_EN
    total_cnt++;
    if ({perf_done_cnt, perf_max_lat} !== 42'd0)
      $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_done_cnt, perf_max_lat);
    else pass_cnt++;
`endif
    resetn = 1'b1;
    step();
  endtask

  task automatic test_single();
    int early;
    apply_reset();
    bus.req_push      = 1'b1;
    bus.req_data      = 64'hDEAD_BEEF;
    bus.fab_req_ready = 1'b1;
    step();
    bus.req_push = 1'b0;
    total_cnt++;
    if (bus.fab_req_valid !== 1'b0) $display("FAIL single_valid_p1 got=%b exp=0", bus.fab_req_valid);
    else pass_cnt++;
    total_cnt++;
    if (bus.pending_cnt !== 3'd1) $display("FAIL single_pending got=%0d exp=1", bus.pending_cnt);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.fab_req_valid !== 1'b1) $display("FAIL single_valid_p2 got=%b exp=1", bus.fab_req_valid);
    else pass_cnt++;
    total_cnt++;
    if (bus.fab_req_data !== 64'hDEAD_BEEF)
      $display("FAIL single_req_data got=%0h exp=deadbeef", bus.fab_req_data);
    else pass_cnt++;
    step();
    bus.fab_req_ready = 1'b0;
    early = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.delayed_valid !== 1'b0 || bus.fab_req_valid !== 1'b0) early++;
      step();
    end
    total_cnt++;
    if (early !== 0) $display("FAIL single_wait_quiet got=%0d exp=0", early);
    else pass_cnt++;
    bus.fab_resp_valid = 1'b1;
    step();
    bus.fab_resp_valid = 1'b0;
    total_cnt++;
    if (bus.delayed_valid !== 1'b1 || bus.delayed_data !== 64'hDEAD_BEEF)
      $display("FAIL single_done got=%b/%0h exp=1/deadbeef", bus.delayed_valid, bus.delayed_data);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.delayed_valid !== 1'b0 || bus.pending_cnt !== 3'd0)
      $display("FAIL single_after got=%b/%0d exp=0/0", bus.delayed_valid, bus.pending_cnt);
    else pass_cnt++;
    total_cnt++;
    if ({bus.timeout_err, bus.ovf_err} !== 2'b00)
      $display("FAIL single_errs got=%b exp=00", {bus.timeout_err, bus.ovf_err});
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [DW-1:0] exp_d;
    apply_reset();
    bus.fab_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin
        total_cnt++;
        if (bus.req_full !== 1'b0) $display("FAIL ovf_full_at3 got=%b exp=0", bus.req_full);
        else pass_cnt++;
      end
      if (i == 4) begin
        total_cnt++;
        if (bus.req_full !== 1'b1) $display("FAIL ovf_full_at4 got=%b exp=1", bus.req_full);
        else pass_cnt++;
      end
      bus.req_push = 1'b1;
      bus.req_data = 64'h100 + 64'(i);
      step();
    end
    bus.req_push = 1'b0;
    total_cnt++;
    if (bus.ovf_err !== 1'b1 || bus.pending_cnt !== 3'd4)
      $display("FAIL ovf_state got=%b/%0d exp=1/4", bus.ovf_err, bus.pending_cnt);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      exp_d = 64'h100 + 64'(i);
      total_cnt++;
      if (bus.fab_req_valid !== 1'b1 || bus.fab_req_data !== exp_d)
        $display("FAIL ovf_issue%0d got=%b/%0h exp=1/%0h", i, bus.fab_req_valid, bus.fab_req_data, exp_d);
      else pass_cnt++;
      bus.fab_req_ready = 1'b1;
      step();
      bus.fab_req_ready  = 1'b0;
      bus.fab_resp_valid = 1'b1;
      step();
      bus.fab_resp_valid = 1'b0;
      total_cnt++;
      if (bus.delayed_valid !== 1'b1 || bus.delayed_data !== exp_d)
        $display("FAIL ovf_done%0d got=%b/%0h exp=1/%0h", i, bus.delayed_valid, bus.delayed_data, exp_d);
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if (bus.fab_req_valid !== 1'b0 || bus.pending_cnt !== 3'd0 || bus.ovf_err !== 1'b1)
      $display("FAIL ovf_drain got=%b/%0d/%b exp=0/0/1", bus.fab_req_valid, bus.pending_cnt, bus.ovf_err);
    else pass_cnt++;
  endtask

  // Leaves the DUT in the first WAIT cycle with one entry of data d queued.
  task automatic enter_wait(input logic [DW-1:0] d);
    bus.req_push = 1'b1;
    bus.req_data = d;
    step();
    bus.req_push = 1'b0;
    step();
    bus.fab_req_ready = 1'b1;
    step();
    bus.fab_req_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int early;
    apply_reset();
    enter_wait(64'hA5);
    early = 0;
    for (int i = 0; i < 1022; i++) begin
      if (bus.delayed_valid !== 1'b0) early++;
      step();
    end
    total_cnt++;
    if (early !== 0 || bus.delayed_valid !== 1'b0 || bus.timeout_err !== 1'b0)
      $display("FAIL to_early got=%0d/%b/%b exp=0/0/0", early, bus.delayed_valid, bus.timeout_err);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.delayed_valid !== 1'b1 || bus.delayed_data !== 64'hA5 || bus.timeout_err !== 1'b1)
      $display("FAIL to_done got=%b/%0h/%b exp=1/a5/1", bus.delayed_valid, bus.delayed_data, bus.timeout_err);
    else pass_cnt++;
    repeat (3) step();
    total_cnt++;
    if (bus.timeout_err !== 1'b1 || bus.delayed_valid !== 1'b0 || bus.pending_cnt !== 3'd0)
      $display("FAIL to_sticky got=%b/%b/%0d exp=1/0/0", bus.timeout_err, bus.delayed_valid, bus.pending_cnt);
    else pass_cnt++;
  endtask

  task automatic test_timeout_tie();
    apply_reset();
    enter_wait(64'h5A);
    repeat (1022) step();
    bus.fab_resp_valid = 1'b1;
    step();
    bus.fab_resp_valid = 1'b0;
    total_cnt++;
    if (bus.delayed_valid !== 1'b1 || bus.delayed_data !== 64'h5A || bus.timeout_err !== 1'b0)
      $display("FAIL tie_done got=%b/%0h/%b exp=1/5a/0", bus.delayed_valid, bus.delayed_data, bus.timeout_err);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.timeout_err !== 1'b0 || bus.delayed_valid !== 1'b0)
      $display("FAIL tie_after got=%b/%b exp=0/0", bus.timeout_err, bus.delayed_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int late;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      bus.req_push = 1'b1;
      bus.req_data = 64'h300 + 64'(i);
      if (i == 2) bus.fab_req_ready = 1'b1;
      step();
    end
    bus.req_push      = 1'b0;
    bus.fab_req_ready = 1'b0;
    step();
    total_cnt++;
    if (bus.pending_cnt !== 3'd3 || bus.fab_req_valid !== 1'b0)
      $display("FAIL mid_pre got=%0d/%b exp=3/0", bus.pending_cnt, bus.fab_req_valid);
    else pass_cnt++;
    #2 resetn = 1'b0;
    #1;
    total_cnt++;
    if ({bus.fab_req_valid, bus.delayed_valid, bus.req_full, bus.timeout_err, bus.ovf_err} !== 5'b0 ||
        bus.pending_cnt !== 3'd0)
      $display("FAIL mid_async got=%b/%0d exp=00000/0",
               {bus.fab_req_valid, bus.delayed_valid, bus.req_full, bus.timeout_err, bus.ovf_err},
               bus.pending_cnt);
    else pass_cnt++;
    #1 resetn = 1'b1;
    step();
    bus.fab_resp_valid = 1'b1;
    step();
    bus.fab_resp_valid = 1'b0;
    late = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.delayed_valid !== 1'b0 || bus.fab_req_valid !== 1'b0 || bus.pending_cnt !== 3'd0) late++;
      step();
    end
    total_cnt++;
    if (late !== 0) $display("FAIL mid_late_resp got=%0d exp=0", late);
    else pass_cnt++;
  endtask

`ifdef DELAYED_TRACKER_PERF_EN
  task automatic test_perf();
    int lats [3];
    lats = '{4, 9, 2};
    apply_reset();
    for (int t = 0; t < 3; t++) begin
      enter_wait(64'h400 + 64'(t));
      repeat (lats[t] - 1) step();
      bus.fab_resp_valid = 1'b1;
      step();
      bus.fab_resp_valid = 1'b0;
      total_cnt++;
      if (bus.delayed_valid !== 1'b1 || bus.delayed_data !== 64'h400 + 64'(t))
        $display("FAIL perf_txn%0d got=%b/%0h exp=1/%0h", t, bus.delayed_valid, bus.delayed_data, 64'h400 + t);
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if (perf_done_cnt !== 32'd3) $display("FAIL perf_done_cnt got=%0d exp=3", perf_done_cnt);
    else pass_cnt++;
    total_cnt++;
    if (perf_max_lat !== 10'd9) $display("FAIL perf_max_lat got=%0d exp=9", perf_max_lat);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_timeout();
    test_timeout_tie();
    test_reset_mid();
`ifdef DELAYED_TRACKER_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
